imm_gen_stage: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. Covers every RV32I immediate format (I, shift-I, S, B, U, J) with correct sign extension to XLEN, and flags unsupported opcodes. Computes the PC-relative target. Sits between fetch and execute behind a valid/ready handshake with optional skid buffering, flush, and an illegal-opcode counter.

---
 rtl/imm_gen_pkg.sv | 31 +++
 rtl/imm_gen_decode.sv | 72 +++++++
 rtl/imm_gen_stage.sv | 123 ++++++++++++
 tb/tb_imm_gen_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate format codes and small decode helpers
// for the decode-stage immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_NONE  = 3'd7
    } fmt_e;

    // slli/srli/srai carry a shift amount, not a signed immediate
    function automatic logic is_shift_imm(input logic [31:0] instr);
        return (instr[6:0] == OP_IMM) && ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101));
    endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational RV32I immediate decoder: instruction word -> sign-extended
// immediate, format code and unsupported-opcode flag.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [31:0] imm32;
    fmt_e        fmt_d;

    always_comb begin
        imm32   = '0;
        fmt_d   = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_IMM: begin
                if (is_shift_imm(instr)) begin
                    fmt_d = FMT_SHAMT;
                    // bit 25 is part of shamt only on a 64-bit datapath
                    imm32 = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
                end else begin
                    fmt_d = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            LOAD, JALR: begin
                fmt_d = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            STORE: begin
                fmt_d = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            BRANCH: begin
                fmt_d = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt_d = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            JAL: begin
                fmt_d = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP: begin
                fmt_d = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign fmt = fmt_d;

    // imm32[31] is the instruction sign bit for every signed format
    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{32{imm32[31]}}, imm32};
        end else begin : g_x32
            assign imm = imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: decodes on the input side, registers the
// result behind a valid/ready handshake (optional skid entry) and adds pc+imm.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry;
    entry_t          main_q;
    logic            main_vld;
    logic            accept;
    logic            drain;

    imm_gen_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_entry = '{instr: in_instr, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = main_vld & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            entry_t skid_q;
            logic   skid_vld;

            // in_ready comes straight from a flop, so out_ready never reaches it
            assign in_ready = ~skid_vld;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                    main_q   <= ENTRY_RST;
                    skid_q   <= ENTRY_RST;
                end else if (flush) begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                end else if (!main_vld || drain) begin
                    // skid only fills behind a valid main entry, so it is older
                    if (skid_vld) begin
                        main_q   <= skid_q;
                        main_vld <= 1'b1;
                        skid_vld <= 1'b0;
                    end else begin
                        main_vld <= accept;
                        if (accept) main_q <= in_entry;
                    end
                end else if (accept) begin
                    skid_q   <= in_entry;
                    skid_vld <= 1'b1;
                end
            end
        end else begin : g_single
            assign in_ready = ~main_vld | out_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    main_vld <= 1'b0;
                    main_q   <= ENTRY_RST;
                end else if (flush) begin
                    main_vld <= 1'b0;
                end else begin
                    if (accept) main_q <= in_entry;
                    main_vld <= accept | (main_vld & ~out_ready);
                end
            end
        end
    endgenerate

    // only words that actually enter the stage are counted; flush blocks accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_count <= '0;
        else if (accept && dec_illegal && (illegal_count != {CNT_W{1'b1}}))
            illegal_count <= illegal_count + CNT_W'(1);
    end

    assign out_valid   = main_vld;
    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_target  = main_q.pc + main_q.imm;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: two configurations (32-bit skid, 64-bit single stage)
// share one directed stimulus; a queue model checks every cycle.
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA immediate layouts
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xl);
        exp_t   e;
        longint s;
        longint t;
        logic [63:0] m;
        s = longint'($signed(ins));
        m = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        e.instr = ins;
        e.pc    = pc & m;
        e.imm   = '0;
        e.fmt   = 3'd7;
        e.ill   = 1'b0;
        case (ins[6:0])
            7'h13: begin
                if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
                    e.fmt = 3'd6;
                    e.imm = (xl == 32) ? 64'(ins[24:20]) : 64'(ins[25:20]);
                end else begin
                    e.fmt = 3'd1;
                    t = s >>> 20;
                    e.imm = t;
                end
            end
            7'h03, 7'h67: begin
                e.fmt = 3'd1;
                t = s >>> 20;
                e.imm = t;
            end
            7'h23: begin
                e.fmt = 3'd2;
                t = s >>> 25;
                e.imm = (t << 5) | 64'(ins[11:7]);
            end
            7'h63: begin
                e.fmt = 3'd3;
                t = s >>> 31;
                e.imm = (t << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                e.imm = s & ~64'hFFF;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                t = s >>> 31;
                e.imm = (t << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            end
            7'h33: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        e.imm = e.imm & m;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int XL = (g == 0) ? 32 : 64;
        localparam int SK = (g == 0) ? 1 : 0;
        localparam int CW = (g == 0) ? 2 : 16;

        logic          o_in_ready;
        logic          o_out_valid;
        logic [31:0]   o_out_instr;
        logic [XL-1:0] o_out_pc;
        logic [XL-1:0] o_out_imm;
        logic [2:0]    o_out_fmt;
        logic [XL-1:0] o_out_target;
        logic          o_out_illegal;
        logic [CW-1:0] o_illegal_count;

        imm_gen_stage #(.XLEN(XL), .SKID(SK), .CNT_W(CW)) dut (
            .clk           (clk),
            .reset         (reset),
            .flush         (flush),
            .in_valid      (in_valid),
            .in_ready      (o_in_ready),
            .in_instr      (in_instr),
            .in_pc         (in_pc[XL-1:0]),
            .out_valid     (o_out_valid),
            .out_ready     (out_ready),
            .out_instr     (o_out_instr),
            .out_pc        (o_out_pc),
            .out_imm       (o_out_imm),
            .out_fmt       (o_out_fmt),
            .out_target    (o_out_target),
            .out_illegal   (o_out_illegal),
            .illegal_count (o_illegal_count)
        );

        exp_t   q[$];
        longint cnt_m;
        longint cmax;
        logic [63:0] msk;
        exp_t   e_in;
        exp_t   e_hd;
        logic   rdy_m;
        logic   drn_m;

        initial begin
            cnt_m = 0;
            cmax  = (longint'(1) << CW) - 1;
            msk   = (XL == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        end

        // model: an in-order queue holding at most two (skid) or one word
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                q.delete();
                cnt_m = 0;
            end else begin
                rdy_m = (SK != 0) ? (q.size() < 2) : (q.size() == 0 || out_ready);
                drn_m = (q.size() > 0) && out_ready;
                if (flush) begin
                    q.delete();
                end else begin
                    if (drn_m) void'(q.pop_front());
                    if (in_valid && rdy_m) begin
                        e_in = ref_dec(in_instr, in_pc, XL);
                        q.push_back(e_in);
                        if (e_in.ill && cnt_m < cmax) cnt_m++;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (!reset) begin
                chk($sformatf("c%0d in_ready", g), o_in_ready,
                    (SK != 0) ? (q.size() < 2) : (q.size() == 0 || out_ready));
                chk($sformatf("c%0d out_valid", g), o_out_valid, q.size() > 0);
                chk($sformatf("c%0d illegal_count", g), o_illegal_count, cnt_m);
                if (q.size() > 0) begin
                    e_hd = q[0];
                    chk($sformatf("c%0d out_instr", g), o_out_instr, e_hd.instr);
                    chk($sformatf("c%0d out_pc", g), o_out_pc, e_hd.pc);
                    chk($sformatf("c%0d out_imm", g), o_out_imm, e_hd.imm);
                    chk($sformatf("c%0d out_fmt", g), o_out_fmt, e_hd.fmt);
                    chk($sformatf("c%0d out_illegal", g), o_out_illegal, e_hd.ill);
                    chk($sformatf("c%0d out_target", g), o_out_target, (e_hd.pc + e_hd.imm) & msk);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] w[4];
    logic [31:0] got[$];
    int idx;
    int cyc;
    logic acc;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) w[i] = ((32'(i) + 32'd1) << 20) | 32'h0000_0093;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", cfg[0].o_in_ready, 1);
        chk("rst out_valid", cfg[0].o_out_valid, 0);
        chk("rst out_fmt", cfg[0].o_out_fmt, 7);
        chk("rst out_imm", cfg[0].o_out_imm, 0);
        chk("rst out_target", cfg[0].o_out_target, 0);
        chk("rst count", cfg[0].o_illegal_count, 0);
        chk("rst out_valid x64", cfg[1].o_out_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic formats
        drive(1, 32'hFFF00093, 64'h0, 1, 0);
        chk("addi imm", cfg[0].o_out_imm, 32'hFFFFFFFF);
        chk("addi fmt", cfg[0].o_out_fmt, 1);
        chk("addi target", cfg[0].o_out_target, 32'hFFFFFFFF);
        chk("addi imm x64", cfg[1].o_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 32'hFE112E23, 64'h4, 1, 0);
        chk("sw imm", cfg[0].o_out_imm, 32'hFFFFFFFC);
        chk("sw fmt", cfg[0].o_out_fmt, 2);
        drive(1, 32'hFE000CE3, 64'h100, 1, 0);
        chk("beq imm", cfg[0].o_out_imm, 32'hFFFFFFF8);
        chk("beq fmt", cfg[0].o_out_fmt, 3);
        chk("beq target", cfg[0].o_out_target, 32'h000000F8);
        drive(1, 32'h800002B7, 64'h8, 1, 0);
        chk("lui imm", cfg[0].o_out_imm, 32'h80000000);
        chk("lui fmt", cfg[0].o_out_fmt, 4);
        chk("lui imm x64", cfg[1].o_out_imm, 64'hFFFF_FFFF_8000_0000);
        drive(1, 32'h4030D093, 64'hC, 1, 0);
        chk("srai fmt", cfg[0].o_out_fmt, 6);
        chk("srai imm", cfg[0].o_out_imm, 3);
        chk("srai imm x64", cfg[1].o_out_imm, 3);
        drive(1, 32'h008000EF, 64'h200, 1, 0);
        chk("jal fmt", cfg[0].o_out_fmt, 5);
        chk("jal target", cfg[0].o_out_target, 32'h208);
        drive(1, 32'h002081B3, 64'h204, 1, 0);
        chk("add fmt", cfg[0].o_out_fmt, 0);
        chk("add imm", cfg[0].o_out_imm, 0);
        drive(1, 32'hFFFFF0B7, 64'hFFFF_FFFF_FFFF_F000, 1, 0);
        chk("wrap target", cfg[0].o_out_target, 32'hFFFFE000);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        // Backpressure stream: out_ready low for 3 cycles
        idx = 0;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            if (idx == 4 && !cfg[0].o_out_valid) break;
            in_valid  = (idx < 4);
            in_instr  = (idx < 4) ? w[idx] : 32'h0;
            in_pc     = 64'(idx * 4);
            out_ready = (c >= 3);
            flush     = 1'b0;
            if (c == 1 || c == 2) chk("stall hold instr", cfg[0].o_out_instr, w[0]);
            if (c == 2) begin
                chk("stall in_ready", cfg[0].o_in_ready, 0);
                chk("stall accepts", idx, 2);
            end
            acc = in_valid & cfg[0].o_in_ready;
            if (cfg[0].o_out_valid && out_ready) got.push_back(cfg[0].o_out_instr);
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("stream accepted", idx, 4);
        chk("stream delivered", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk($sformatf("stream order %0d", i), got[i], w[i]);

        // Same stream, no backpressure: one word per cycle
        idx = 0;
        cyc = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid  = 1'b1;
            in_instr  = w[idx];
            in_pc     = 64'(idx * 4);
            out_ready = 1'b1;
            acc = cfg[0].o_in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) idx++;
        end
        chk("throughput cycles", cyc, 4);
        drive(0, 0, 0, 1, 0);

        // Flush with both entries occupied and an illegal word presented
        drive(1, 32'h00500093, 64'h10, 0, 0);
        drive(1, 32'h00600093, 64'h14, 0, 0);
        chk("full in_ready", cfg[0].o_in_ready, 0);
        drive(1, 32'h0000007F, 64'h18, 0, 1);
        chk("flush out_valid", cfg[0].o_out_valid, 0);
        chk("flush in_ready", cfg[0].o_in_ready, 1);
        chk("flush count", cfg[0].o_illegal_count, 0);
        drive(0, 0, 0, 1, 0);
        chk("flush dropped", cfg[0].o_out_valid, 0);

        // Illegal opcodes with a 2-bit saturating counter
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h0000007F | (32'(k) << 7), 64'(32 + k * 4), 1, 0);
            chk($sformatf("ill%0d flag", k), cfg[0].o_out_illegal, 1);
            chk($sformatf("ill%0d fmt", k), cfg[0].o_out_fmt, 7);
            chk($sformatf("ill%0d imm", k), cfg[0].o_out_imm, 0);
            chk($sformatf("ill%0d count", k), cfg[0].o_illegal_count, (k < 3) ? k + 1 : 3);
        end
        chk("ill count x64", cfg[1].o_illegal_count, 5);

        // Reset in the middle of a transfer
        in_valid = 1'b1;
        in_instr = 32'h0000007F;
        #2 reset = 1'b1;
        #1;
        chk("midrst count", cfg[0].o_illegal_count, 0);
        chk("midrst out_valid", cfg[0].o_out_valid, 0);
        chk("midrst count x64", cfg[1].o_illegal_count, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1, 32'h00A00093, 64'h40, 1, 0);
        chk("post rst imm", cfg[0].o_out_imm, 10);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
